// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Big-endian byte lanes on a word RAM, one request in flight at a time.
module dmem_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic accept;

    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [31:0] mem [DEPTH];

    logic        op_ok;
    logic        is_store;
    logic        sext;
    size_t       size;
    logic        misaligned;
    logic        err;
    logic [1:0]  lane;
    logic [ADDR_W-3:0] widx;
    logic [31:0] word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] st_data;
    logic [3:0]  be;
    logic        we;

    always_comb begin
        op_ok    = 1'b1;
        is_store = 1'b0;
        sext     = 1'b0;
        size     = SZ_W;
        case (op_q)
            6'b100000: begin size = SZ_B; sext = 1'b1; end
            6'b100100: size = SZ_B;
            6'b100001: begin size = SZ_H; sext = 1'b1; end
            6'b100101: size = SZ_H;
            6'b100011: size = SZ_W;
            6'b101000: begin size = SZ_B; is_store = 1'b1; end
            6'b101001: begin size = SZ_H; is_store = 1'b1; end
            6'b101011: begin size = SZ_W; is_store = 1'b1; end
            default:   op_ok = 1'b0;
        endcase
    end

    assign lane = addr_q[1:0];
    assign widx = addr_q[ADDR_W-1:2];
    assign misaligned = (size == SZ_H && lane[0])
                     || (size == SZ_W && lane != 2'b00);
    assign err = !op_ok || misaligned;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Lane 0 is the most significant byte of the word.
    assign word = mem[widx];

    always_comb begin
        case (lane)
            2'd0:    ld_byte = word[31:24];
            2'd1:    ld_byte = word[23:16];
            2'd2:    ld_byte = word[15:8];
            default: ld_byte = word[7:0];
        endcase
        ld_half = lane[1] ? word[15:0] : word[31:16];
        ld_data = word;
        case (size)
            SZ_B: ld_data = sext ? {{24{ld_byte[7]}}, ld_byte}
                                 : {24'd0, ld_byte};
            SZ_H: ld_data = sext ? {{16{ld_half[15]}}, ld_half}
                                 : {16'd0, ld_half};
            default: ld_data = word;
        endcase
    end

    always_comb begin
        st_data = wdata_q;
        be      = 4'b1111;
        case (size)
            SZ_B: begin
                st_data = {4{wdata_q[7:0]}};
                be      = 4'b0001 << lane;
            end
            SZ_H: begin
                st_data = {2{wdata_q[15:0]}};
                be      = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = wdata_q;
                be      = 4'b1111;
            end
        endcase
    end

    // Commit on the edge closing RESP; a reset on that edge drops it.
    assign we = (state_q == RESP) && is_store && !err && rst;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][31-8*i -: 8] <= st_data[31-8*i -: 8];
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = !req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err;
    assign rsp_rdata = (rsp_valid && !err && !is_store) ? ld_data : '0;

endmodule
